mm_tile_feeder: RTL and testbench

- Upstream feeder for the 16x16 matrix-vector multiply array.
- Accepts a single narrow valid/ready beat stream of width DW*N and assembles M matrix beats into the stationary matrix operand, then issues each following vector beat as a one-cycle `input_valid` pulse.
- Tracks in-flight vectors using the array's `add_valid` pulse, so the matrix operand never changes while results are pending and a bounded number of vectors are outstanding.

---
 rtl/mm_tile_feeder.sv | 113 +++++++++++
 tb/tb_mm_tile_feeder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mm_tile_feeder.sv
// Feeds the 16x16 matrix-vector array: assembles M matrix beats into a stationary
// operand, then issues vector beats as one-cycle pulses while tracking in-flight results.
module mm_tile_feeder #(
   parameter int M       = 16,
   parameter int N       = 16,
   parameter int DW      = 32,
   parameter int MAX_OUT = 8,
   localparam int OW     = $clog2(MAX_OUT + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DW*N-1:0]     s_data,
   input  logic                s_kind,
   input  logic                s_valid,
   output logic                s_ready,
   output logic [DW*N*M-1:0]   matrix_input,
   output logic [DW*N-1:0]     vector_input,
   output logic                input_valid,
   input  logic                add_valid,
   output logic                mat_loaded,
   output logic [OW-1:0]       outstanding,
   output logic                err_underflow
);

   localparam int BW = DW * N;
   localparam int CW = (M > 1) ? $clog2(M) : 1;

   typedef enum logic [1:0] {EMPTY, LOADING, LOADED} state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [CW-1:0]      wr_idx;
   logic [BW*M-1:0]    mat_q, mat_d;
   logic [BW-1:0]      vec_q, vec_d;
   logic               valid_q, valid_d;
   logic [OW-1:0]      out_q, out_d;
   logic               err_q, err_d;
   logic               acc_mat, acc_vec;

   // A new tile may only start once every issued vector has retired and no pulse is on the wire.
   always_comb begin
      s_ready = 1'b0;
      if (!rst) begin
         unique case (state_q)
            EMPTY, LOADING: s_ready = s_kind;
            LOADED:         s_ready = s_kind ? ((out_q == '0) && !valid_q)
                                             : (out_q < OW'(MAX_OUT));
            default:        s_ready = 1'b0;
         endcase
      end
   end

   assign acc_mat = s_valid && s_ready && s_kind;
   assign acc_vec = s_valid && s_ready && !s_kind;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mat_d   = mat_q;
      wr_idx  = (state_q == LOADING) ? cnt_q : '0;
      if (acc_mat) begin
         mat_d[int'(wr_idx)*BW +: BW] = s_data;
         if (wr_idx == CW'(M - 1)) begin
            state_d = LOADED;
            cnt_d   = '0;
         end else begin
            state_d = LOADING;
            cnt_d   = wr_idx + CW'(1);
         end
      end
   end

   // Simultaneous issue and retire cancel; a retire with nothing in flight only flags an error.
   always_comb begin
      vec_d   = acc_vec ? s_data : vec_q;
      valid_d = acc_vec;
      out_d   = out_q;
      err_d   = err_q | (add_valid && (out_q == '0));
      if (acc_vec && !add_valid) begin
         out_d = out_q + OW'(1);
      end else if (!acc_vec && add_valid && (out_q != '0)) begin
         out_d = out_q - OW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         cnt_q   <= '0;
         mat_q   <= '0;
         vec_q   <= '0;
         valid_q <= 1'b0;
         out_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mat_q   <= mat_d;
         vec_q   <= vec_d;
         valid_q <= valid_d;
         out_q   <= out_d;
         err_q   <= err_d;
      end
   end

   assign matrix_input  = mat_q;
   assign vector_input  = vec_q;
   assign input_valid   = valid_q;
   assign mat_loaded    = (state_q == LOADED);
   assign outstanding   = out_q;
   assign err_underflow = err_q;

endmodule

// File: tb/tb_mm_tile_feeder.sv
// Self-checking bench for mm_tile_feeder: directed scenarios followed by random traffic,
// all checked every cycle against a tile/in-flight reference model.
module tb_mm_tile_feeder;

   localparam int M       = 16;
   localparam int N       = 16;
   localparam int DW      = 32;
   localparam int MAX_OUT = 8;
   localparam int BW      = DW * N;
   localparam int OW      = $clog2(MAX_OUT + 1);

   logic              clk = 1'b0;
   logic              rst;
   logic [BW-1:0]     s_data;
   logic              s_kind;
   logic              s_valid;
   logic              s_ready;
   logic [BW*M-1:0]   matrix_input;
   logic [BW-1:0]     vector_input;
   logic              input_valid;
   logic              add_valid;
   logic              mat_loaded;
   logic [OW-1:0]     outstanding;
   logic              err_underflow;

   int checks = 0;
   int errors = 0;

   // Reference model: the tile as an array of slices, how many beats of a new tile have
   // arrived, whether a full tile is held, and how many vectors await their result.
   logic [BW-1:0] mdlMat [M];
   int            beatsGot;
   bit            haveTile;
   int            inFlight;
   bit            pulse;
   logic [BW-1:0] lastVec;
   bit            sticky;

   mm_tile_feeder #(.M(M), .N(N), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_kind(s_kind), .s_valid(s_valid),
      .s_ready(s_ready), .matrix_input(matrix_input), .vector_input(vector_input),
      .input_valid(input_valid), .add_valid(add_valid), .mat_loaded(mat_loaded),
      .outstanding(outstanding), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [BW-1:0] observed,
                              input logic [BW-1:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [BW-1:0] patBeat(input int value);
      logic [BW-1:0] r;
      for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'(value);
      return r;
   endfunction

   function automatic logic [BW-1:0] randBeat();
      logic [BW-1:0] r;
      for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'($urandom);
      return r;
   endfunction

   function automatic bit modelReady(input bit rstIn, input bit kindIn);
      if (rstIn) return 1'b0;
      if (kindIn) return !haveTile || (inFlight == 0 && !pulse);
      return haveTile && (inFlight < MAX_OUT);
   endfunction

   task automatic modelReset();
      for (int k = 0; k < M; k++) mdlMat[k] = '0;
      beatsGot = 0;
      haveTile = 1'b0;
      inFlight = 0;
      pulse    = 1'b0;
      lastVec  = '0;
      sticky   = 1'b0;
   endtask

   // One clock cycle: drive, check ready, clock, advance the model, check every output.
   task automatic applyStimulus(input bit rstIn, input bit validIn, input bit kindIn,
                                input logic [BW-1:0] dataIn, input bit addIn);
      bit expReady, accMat, accVec;
      rst       = rstIn;
      s_valid   = validIn;
      s_kind    = kindIn;
      s_data    = dataIn;
      add_valid = addIn;
      #1;
      expReady = modelReady(rstIn, kindIn);
      checkOutput("s_ready", BW'(s_ready), BW'(expReady));
      accMat = validIn && expReady && kindIn;
      accVec = validIn && expReady && !kindIn;
      @(posedge clk);
      #1;
      if (rstIn) begin
         modelReset();
      end else begin
         if (accMat) begin
            if (haveTile) begin
               haveTile = 1'b0;
               beatsGot = 0;
            end
            mdlMat[beatsGot] = dataIn;
            beatsGot++;
            if (beatsGot == M) begin
               haveTile = 1'b1;
               beatsGot = 0;
            end
         end
         if (addIn && inFlight == 0) sticky = 1'b1;
         if (accVec && !addIn) inFlight++;
         else if (!accVec && addIn && inFlight > 0) inFlight--;
         pulse = accVec;
         if (accVec) lastVec = dataIn;
      end
      checkOutput("input_valid", BW'(input_valid), BW'(pulse));
      checkOutput("vector_input", vector_input, lastVec);
      checkOutput("outstanding", BW'(outstanding), BW'(inFlight));
      checkOutput("mat_loaded", BW'(mat_loaded), BW'(haveTile));
      checkOutput("err_underflow", BW'(err_underflow), BW'(sticky));
      for (int k = 0; k < M; k++)
         checkOutput($sformatf("matrix[%0d]", k), matrix_input[k*BW +: BW], mdlMat[k]);
   endtask

   initial begin
      bit rstR, validR, kindR, addR;
      modelReset();
      rst = 1'b1; s_valid = 1'b0; s_kind = 1'b0; s_data = '0; add_valid = 1'b0;
      @(posedge clk);
      #1;
      repeat (2) applyStimulus(1, 1, 1, randBeat(), 0);

      $display("[TB] load tile");
      for (int k = 0; k < M; k++) applyStimulus(0, 1, 1, patBeat(k + 1), 0);
      for (int k = 0; k < M; k++)
         checkOutput($sformatf("tile_slice%0d", k), matrix_input[k*BW +: BW], patBeat(k + 1));
      checkOutput("tile_loaded", BW'(mat_loaded), BW'(1));

      $display("[TB] vector issue and backpressure");
      applyStimulus(0, 1, 0, BW'(32'hA), 0);
      applyStimulus(0, 1, 0, BW'(32'hB), 0);
      applyStimulus(0, 1, 0, BW'(32'hC), 0);
      checkOutput("three_issued", BW'(outstanding), BW'(3));
      for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, randBeat(), 0);
      applyStimulus(0, 1, 0, randBeat(), 0);
      checkOutput("full_stalled", BW'(outstanding), BW'(MAX_OUT));
      applyStimulus(0, 1, 0, randBeat(), 1);
      applyStimulus(0, 1, 0, randBeat(), 0);

      $display("[TB] matrix swap waits for retirement");
      for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, '0, 1);
      checkOutput("two_in_flight", BW'(outstanding), BW'(2));
      applyStimulus(0, 1, 1, patBeat(99), 1);
      applyStimulus(0, 1, 1, patBeat(99), 1);
      applyStimulus(0, 1, 1, patBeat(99), 0);
      for (int k = 1; k < M; k++) applyStimulus(0, 1, 1, patBeat(100 + k), 0);

      $display("[TB] simultaneous issue/retire and underflow");
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, randBeat(), 0);
      applyStimulus(0, 1, 0, randBeat(), 1);
      checkOutput("simultaneous", BW'(outstanding), BW'(4));
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, '0, 1);
      applyStimulus(0, 0, 0, '0, 0);
      applyStimulus(0, 0, 0, '0, 0);
      checkOutput("underflow_sticky", BW'(err_underflow), BW'(1));

      $display("[TB] reset mid-load");
      for (int k = 0; k < 7; k++) applyStimulus(0, 1, 1, randBeat(), 0);
      applyStimulus(1, 0, 0, '0, 0);
      checkOutput("reset_matrix_zero", BW'(matrix_input != '0), BW'(0));
      applyStimulus(0, 1, 0, randBeat(), 0);

      $display("[TB] random traffic");
      for (int c = 0; c < 2000; c++) begin
         rstR   = ($urandom_range(0, 299) == 0);
         validR = ($urandom_range(0, 3) != 0);
         kindR  = ($urandom_range(0, 9) < 2);
         addR   = (inFlight > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
         applyStimulus(rstR, validR, kindR, randBeat(), addR);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
